c432_key_sched_ctrl: RTL and testbench

- Sequencing controller for the key-programmable (camouflaged-gate) c432 netlist.
- Serially loads a 12-bit key and drives it onto the netlist's s_0..s_11 select inputs.
- Gates evaluation traffic until a valid key is committed.
- Applies 36-bit input vectors with a valid/ready handshake, waits a programmable settle time, then captures and returns the 7 primary outputs.

---
 rtl/c432_key_sched_ctrl.sv | 137 +++++++++++++
 tb/tb_c432_key_sched_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/c432_key_sched_ctrl.sv
// Key-load and evaluation sequencer for the key-programmable c432 netlist.
// Optional macro C432_KEY_LOCKOUT_EN: after the first commit, later commits are refused until RST.
module c432_key_sched_ctrl #(
  parameter int unsigned            KEY_W         = 12,
  parameter int unsigned            PI_W          = 36,
  parameter int unsigned            PO_W          = 7,
  parameter int unsigned            SETTLE_CYCLES = 2,
  parameter logic [KEY_W-1:0]       KEY_RESET     = 12'h000
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              key_sin,
  input  logic              key_sen,
  input  logic              key_commit,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              key_err,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [PI_W-1:0]   vec_data,
  output logic [PI_W-1:0]   pi_out,
  input  logic [PO_W-1:0]   po_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PO_W-1:0]   res_data,
  output logic              busy
);

  localparam int unsigned SC_W  = $clog2(KEY_W + 1);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(KEY_W);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  state_t             state_q;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [SC_W-1:0]    shift_cnt_q, shift_cnt_d;
  logic [KEY_W-1:0]   key_out_q, pend_key_q;
  logic               key_valid_q, key_err_q, commit_pend_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PI_W-1:0]    pi_out_q;
  logic               res_valid_q;
  logic [PO_W-1:0]    res_data_q;
  logic               commit_ok, commit_bad;

  // The shift of the current cycle is folded in before the commit looks at the count.
  always_comb begin
    shadow_d    = shadow_q;
    shift_cnt_d = shift_cnt_q;
    if (key_sen) begin
      shadow_d = {shadow_q[KEY_W-2:0], key_sin};
      if (shift_cnt_q != SC_FULL) shift_cnt_d = shift_cnt_q + 1'b1;
    end
`ifdef C432_KEY_LOCKOUT_EN
    commit_ok = key_commit && (shift_cnt_d == SC_FULL) && !key_valid_q;
`else
    commit_ok = key_commit && (shift_cnt_d == SC_FULL);
`endif
    commit_bad = key_commit && !commit_ok;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      shift_cnt_q   <= '0;
      key_out_q     <= KEY_RESET;
      pend_key_q    <= '0;
      key_valid_q   <= 1'b0;
      key_err_q     <= 1'b0;
      commit_pend_q <= 1'b0;
      cnt_q         <= '0;
      pi_out_q      <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      shadow_q    <= shadow_d;
      shift_cnt_q <= shift_cnt_d;
      if (commit_bad) key_err_q <= 1'b1;

      if (state_q == IDLE && commit_pend_q) begin
        key_out_q     <= pend_key_q;
        key_valid_q   <= 1'b1;
        commit_pend_q <= 1'b0;
      end

      // A deferred commit latches the shadow so later shifting cannot alter it.
      if (commit_ok) begin
        shift_cnt_q <= '0;
        if (state_q == IDLE) begin
          key_out_q     <= shadow_d;
          key_valid_q   <= 1'b1;
          commit_pend_q <= 1'b0;
        end else begin
          pend_key_q    <= shadow_d;
          commit_pend_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (vec_valid && vec_ready) begin
            pi_out_q <= vec_data;
            cnt_q    <= CNT_W'(SETTLE_CYCLES - 1);
            state_q  <= APPLY;
          end
        end
        APPLY: begin
          if (cnt_q == '0) begin
            res_data_q  <= po_in;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign vec_ready = (state_q == IDLE) && key_valid_q && !commit_pend_q;
  assign pi_out    = pi_out_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_c432_key_sched_ctrl.sv
// Directed self-checking bench for c432_key_sched_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_c432_key_sched_ctrl;

  logic        CK = 1'b0;
  logic        RST;
  logic        key_sin, key_sen, key_commit;
  logic [11:0] key_out;
  logic        key_valid, key_err;
  logic        vec_valid, vec_ready;
  logic [35:0] vec_data, pi_out;
  logic [6:0]  po_in, res_data;
  logic        res_valid, res_ready, busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  c432_key_sched_ctrl #(.KEY_W(12), .PI_W(36), .PO_W(7), .SETTLE_CYCLES(2)) dut (
    .CK(CK), .RST(RST),
    .key_sin(key_sin), .key_sen(key_sen), .key_commit(key_commit),
    .key_out(key_out), .key_valid(key_valid), .key_err(key_err),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .pi_out(pi_out), .po_in(po_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CK);
  endtask

  task automatic shift_key(input logic [11:0] k, input int unsigned nbits);
    for (int i = int'(nbits) - 1; i >= 0; i--) begin
      key_sen = 1'b1;
      key_sin = k[i];
      tick();
    end
    key_sen = 1'b0;
    key_sin = 1'b0;
  endtask

  task automatic commit_key();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; key_sin = 0; key_sen = 0; key_commit = 0;
    vec_valid = 0; vec_data = '0; po_in = 7'h55; res_ready = 0;
    tick(); tick();
    RST = 1'b0;
    tick();
    check("rst_key_out",   key_out,   12'h000);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_err",   key_err,   0);
    check("rst_res_valid", res_valid, 0);
    check("rst_pi_out",    pi_out,    0);
    check("rst_busy",      busy,      0);

    // No key: vectors must be gated.
    vec_valid = 1'b1;
    vec_data  = 36'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("nokey_vec_ready", vec_ready, 0);
      check("nokey_res_valid", res_valid, 0);
    end
    vec_valid = 1'b0;
    check("nokey_key_out", key_out, 12'h000);

    // Full key load.
    shift_key(12'hA5C, 12);
    check("preload_key_valid", key_valid, 0);
    commit_key();
    check("load_key_out",   key_out,   12'hA5C);
    check("load_key_valid", key_valid, 1);
    check("load_key_err",   key_err,   0);

    // Short shift: commit refused, sticky error.
    shift_key(12'h015, 5);
    commit_key();
    check("short_key_out", key_out, 12'hA5C);
    check("short_key_err", key_err, 1);
    tick(); tick();
    check("short_err_sticky", key_err, 1);

    // Evaluation with delayed res_ready.
    check("tx_vec_ready_idle", vec_ready, 1);
    vec_valid = 1'b1;
    vec_data  = 36'h0_0000_0001;
    tick();
    vec_valid = 1'b0;
    check("tx_busy_apply", busy, 1);
    check("tx_pi_out",     pi_out, 36'h1);
    check("tx_vec_ready_busy", vec_ready, 0);
    check("tx_res_valid_a1", res_valid, 0);
    tick();
    check("tx_res_valid_a2_pre", res_valid, 0);
    tick();
    check("tx_res_valid", res_valid, 1);
    check("tx_res_data",  res_data,  7'h55);
    po_in = 7'h2A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data",  res_data,  7'h55);
      check("hold_vec_ready", vec_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("ret_res_valid", res_valid, 0);
    check("ret_busy",      busy,      0);
    check("ret_vec_ready", vec_ready, 1);
    check("ret_pi_hold",   pi_out,    36'h1);

    // Commit issued during APPLY is deferred until the return to IDLE.
    shift_key(12'h3C9, 12);
    check("preshift_key_out", key_out, 12'hA5C);
    po_in     = 7'h11;
    vec_valid = 1'b1;
    vec_data  = 36'h8_0000_0002;
    tick();
    vec_valid  = 1'b0;
    key_commit = 1'b1;
    check("pend_busy", busy, 1);
    tick();
    key_commit = 1'b0;
    res_ready  = 1'b1;
    check("pend_key_out_apply", key_out, 12'hA5C);
    tick();
    check("pend_res_valid", res_valid, 1);
    check("pend_res_data",  res_data,  7'h11);
    check("pend_key_out_hold", key_out, 12'hA5C);
    tick();
    res_ready = 1'b0;
    check("pend_idle_busy", busy, 0);
    check("pend_idle_key_out", key_out, 12'hA5C);
`ifdef C432_KEY_LOCKOUT_EN
    check("pend_idle_vec_ready", vec_ready, 1);
    tick();
    check("lock_key_out", key_out, 12'hA5C);
`else
    check("pend_idle_vec_ready", vec_ready, 0);
    tick();
    check("pend_new_key_out", key_out, 12'h3C9);
    check("pend_new_vec_ready", vec_ready, 1);
`endif
    check("pend_key_valid", key_valid, 1);

    // Asynchronous reset while holding a result.
    po_in     = 7'h7F;
    vec_valid = 1'b1;
    vec_data  = 36'hF_0F0F_0F0F;
    tick();
    vec_valid = 1'b0;
    tick(); tick();
    check("pre_rst_res_valid", res_valid, 1);
    check("pre_rst_pi_out",    pi_out,    36'hF_0F0F_0F0F);
    #2 RST = 1'b1;
    #1;
    check("arst_res_valid", res_valid, 0);
    check("arst_pi_out",    pi_out,    0);
    check("arst_key_valid", key_valid, 0);
    check("arst_key_out",   key_out,   12'h000);
    check("arst_key_err",   key_err,   0);
    check("arst_busy",      busy,      0);
    check("arst_res_data",  res_data,  0);
    tick();
    RST = 1'b0;
    tick();

    // Re-commit after a first key.
    shift_key(12'h5A3, 12);
    commit_key();
    check("first_key_out", key_out, 12'h5A3);
    check("first_key_err", key_err, 0);
    shift_key(12'h0F0, 12);
    commit_key();
`ifdef C432_KEY_LOCKOUT_EN
    check("second_key_out", key_out, 12'h5A3);
    check("second_key_err", key_err, 1);
`else
    check("second_key_out", key_out, 12'h0F0);
    check("second_key_err", key_err, 0);
`endif
    check("second_key_valid", key_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
